// File: rtl/demux_deser2_pkg.sv
// -----------------------------------------------------------------------------
// demux_deser2_pkg
// Shared constants for the two-channel demux deserializer.
//   W_DEFAULT : default word width per channel
//   W_MIN/MAX : legal word width range
//   CH0/CH1   : channel indices (select value and ovf bit position)
// -----------------------------------------------------------------------------
package demux_deser2_pkg;

  localparam int W_DEFAULT = 8;
  localparam int W_MIN     = 2;
  localparam int W_MAX     = 16;

  localparam int CH0 = 0;
  localparam int CH1 = 1;

  localparam int NUM_CH = 2;

endpackage : demux_deser2_pkg

// File: rtl/demux_deser2_if.sv
// -----------------------------------------------------------------------------
// demux_deser2_if
// Bit-stream inputs and per-channel word handshakes of demux_deser2.
//   bit_vld, s, y0, y1 : one demuxed bit per cycle when bit_vld=1
//   sync               : frame resync (drops partial words)
//   clr_ovf            : clears sticky overflow flags
//   chN_data/valid/ready : per-channel word handshake
//   ovf                : sticky overflow, bit N = channel N
//
// Handshake: a word moves from producer to consumer at a rising edge where
// chN_valid=1 and chN_ready=1. While chN_valid=1 and chN_ready=0 the producer
// keeps chN_data and chN_valid unchanged. valid never waits on ready.
//
// Modports: master = stimulus/consumer side, slave = the deserializer.
// -----------------------------------------------------------------------------
interface demux_deser2_if #(
  parameter int W = demux_deser2_pkg::W_DEFAULT
);

  logic         bit_vld;
  logic         s;
  logic         y0;
  logic         y1;
  logic         sync;
  logic         clr_ovf;
  logic [W-1:0] ch0_data;
  logic         ch0_valid;
  logic         ch0_ready;
  logic [W-1:0] ch1_data;
  logic         ch1_valid;
  logic         ch1_ready;
  logic [1:0]   ovf;

  modport master (
    output bit_vld, s, y0, y1, sync, clr_ovf, ch0_ready, ch1_ready,
    input  ch0_data, ch0_valid, ch1_data, ch1_valid, ovf
  );

  modport slave (
    input  bit_vld, s, y0, y1, sync, clr_ovf, ch0_ready, ch1_ready,
    output ch0_data, ch0_valid, ch1_data, ch1_valid, ovf
  );

endinterface : demux_deser2_if

// File: rtl/demux_deser2_lane.sv
// -----------------------------------------------------------------------------
// deser_lane
// One channel of the deserializer: LSB-first shift register, bit counter,
// single-entry holding register with valid/ready output, sticky overflow.
//   clk, rst_n  : clock, async active-low reset
//   i_bit_vld   : a bit for this lane is present
//   i_bit       : the bit value
//   i_sync      : clear counter and partial word, drop any bit this cycle
//   i_clr_ovf   : clear sticky overflow (a new overflow at the same edge wins)
//   i_ready     : consumer accepts the held word
//   o_data      : held word
//   o_valid     : held word valid
//   o_ovf       : sticky overflow flag
// -----------------------------------------------------------------------------
module deser_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_bit_vld,
  input  logic         i_bit,
  input  logic         i_sync,
  input  logic         i_clr_ovf,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_ovf
);

  localparam int CW = $clog2(W);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_shift;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_ovf;

  logic          w_take;
  logic          w_last;
  logic          w_free;
  logic [W-1:0]  w_word;

  // sync overrides a bit arriving at the same edge: that bit is dropped.
  assign w_take = i_bit_vld & ~i_sync;
  assign w_last = w_take & (r_cnt == CW'(W - 1));
  // Holding register can take a new word if empty or being drained now.
  assign w_free = ~r_valid | i_ready;
  // The final bit goes straight into the top position of the loaded word.
  assign w_word = {i_bit, r_shift[W-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_sync) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_take) begin
      if (w_last) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        r_cnt          <= r_cnt + 1'b1;
        r_shift[r_cnt] <= i_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_last && w_free) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last && !w_free) begin
      r_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule : deser_lane

// File: rtl/demux_deser2.sv
// -----------------------------------------------------------------------------
// demux_deser2
// Reassembles two independent W-bit words from the outputs of an upstream
// 1:2 bit demux. Each accepted bit is steered to the lane chosen by s.
//   clk   : clock, rising edge
//   rst_n : async active-low reset
//   bus   : demux_deser2_if.slave (bit stream, sync, clr_ovf, two word
//           handshakes, sticky ovf)
// -----------------------------------------------------------------------------
module demux_deser2
  import demux_deser2_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_deser2_if.slave        bus
);

  logic [NUM_CH-1:0] w_vld;
  logic              w_bit;
  logic [W-1:0]      w_data0;
  logic [W-1:0]      w_data1;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_ovf;

  // The selected demux output carries the bit; only the selected lane sees
  // a strobe, so the other lane holds its state.
  assign w_bit       = bus.s ? bus.y1 : bus.y0;
  assign w_vld[CH0]  = bus.bit_vld & ~bus.s;
  assign w_vld[CH1]  = bus.bit_vld &  bus.s;

  deser_lane #(.W(W)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bit_vld (w_vld[CH0]),
    .i_bit     (w_bit),
    .i_sync    (bus.sync),
    .i_clr_ovf (bus.clr_ovf),
    .i_ready   (bus.ch0_ready),
    .o_data    (w_data0),
    .o_valid   (w_valid[CH0]),
    .o_ovf     (w_ovf[CH0])
  );

  deser_lane #(.W(W)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_bit_vld (w_vld[CH1]),
    .i_bit     (w_bit),
    .i_sync    (bus.sync),
    .i_clr_ovf (bus.clr_ovf),
    .i_ready   (bus.ch1_ready),
    .o_data    (w_data1),
    .o_valid   (w_valid[CH1]),
    .o_ovf     (w_ovf[CH1])
  );

  assign bus.ch0_data  = w_data0;
  assign bus.ch1_data  = w_data1;
  assign bus.ch0_valid = w_valid[CH0];
  assign bus.ch1_valid = w_valid[CH1];
  assign bus.ovf       = w_ovf;

endmodule : demux_deser2

// File: tb/tb_demux_deser2.sv
// -----------------------------------------------------------------------------
// tb_demux_deser2
// Directed bench for demux_deser2 with W=8 and hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_demux_deser2;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  demux_deser2_if #(.W(W)) bus ();

  demux_deser2 #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change 1 time unit after the rising edge; outputs are also read
  // there, so they reflect the state loaded by the edge just passed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Puts b on the selected demux output and its inverse on the other, so any
  // cross-talk between lanes corrupts the words.
  task automatic send_bit(input logic ch, input logic b);
    bus.bit_vld = 1'b1;
    bus.s       = ch;
    bus.y0      = ch ? ~b : b;
    bus.y1      = ch ? b : ~b;
    tick();
    bus.bit_vld = 1'b0;
  endtask

  task automatic send_bits(input logic ch, input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(ch, w[i]);
  endtask

  task automatic pulse_ready(input logic ch);
    if (ch) bus.ch1_ready = 1'b1; else bus.ch0_ready = 1'b1;
    tick();
    bus.ch0_ready = 1'b0;
    bus.ch1_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.bit_vld   = 1'b0;
    bus.s         = 1'b0;
    bus.y0        = 1'b0;
    bus.y1        = 1'b0;
    bus.sync      = 1'b0;
    bus.clr_ovf   = 1'b0;
    bus.ch0_ready = 1'b0;
    bus.ch1_ready = 1'b0;
    tick();
    tick();

    check("rst_ch0_data",  bus.ch0_data,  16'h0000);
    check("rst_ch1_data",  bus.ch1_data,  16'h0000);
    check("rst_ch0_valid", bus.ch0_valid, 16'h0);
    check("rst_ch1_valid", bus.ch1_valid, 16'h0);
    check("rst_ovf",       bus.ovf,       16'h0);
    rst_n = 1'b1;
    tick();

    // Bits 1,0,1,1,0,0,1,0 LSB-first -> 0x4D, valid right after the 8th edge.
    send_bits(1'b0, 8'h4D, 7);
    check("w4d_valid_before_last", bus.ch0_valid, 16'h0);
    send_bit(1'b0, 1'b0);
    check("w4d_valid",  bus.ch0_valid, 16'h1);
    check("w4d_data",   bus.ch0_data,  16'h004D);
    check("w4d_ch1_valid", bus.ch1_valid, 16'h0);
    tick();
    check("w4d_hold_data",  bus.ch0_data,  16'h004D);
    check("w4d_hold_valid", bus.ch0_valid, 16'h1);
    pulse_ready(1'b0);
    check("w4d_consumed", bus.ch0_valid, 16'h0);

    // Interleaved channels: ch0 all ones, ch1 all zeros.
    for (int i = 0; i < W; i++) begin
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
    end
    check("ilv_ch0_valid", bus.ch0_valid, 16'h1);
    check("ilv_ch1_valid", bus.ch1_valid, 16'h1);
    check("ilv_ch0_data",  bus.ch0_data,  16'h00FF);
    check("ilv_ch1_data",  bus.ch1_data,  16'h0000);
    bus.ch0_ready = 1'b1;
    pulse_ready(1'b1);
    check("ilv_ch0_drained", bus.ch0_valid, 16'h0);
    check("ilv_ch1_drained", bus.ch1_valid, 16'h0);

    // Overflow on ch0: second word discarded, flag sticky until cleared.
    send_bits(1'b0, 8'hA5, W);
    check("ovf_first_data", bus.ch0_data, 16'h00A5);
    check("ovf_not_yet",    bus.ovf,      16'h0);
    send_bits(1'b0, 8'h3C, W);
    check("ovf_kept_data",  bus.ch0_data,  16'h00A5);
    check("ovf_kept_valid", bus.ch0_valid, 16'h1);
    check("ovf_set",        bus.ovf,       16'h1);
    tick();
    check("ovf_sticky",     bus.ovf,       16'h1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_cleared",    bus.ovf,       16'h0);
    check("ovf_clr_keeps_data", bus.ch0_data, 16'h00A5);

    // Accept at the completing edge: A5 leaves, 3C loads, no overflow.
    send_bits(1'b0, 8'h3C, W - 1);
    bus.ch0_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    bus.ch0_ready = 1'b0;
    check("acc_same_edge_data",  bus.ch0_data,  16'h003C);
    check("acc_same_edge_valid", bus.ch0_valid, 16'h1);
    check("acc_same_edge_ovf",   bus.ovf,       16'h0);

    // Overflow and clr_ovf at the same edge: overflow wins.
    send_bits(1'b0, 8'h55, W - 1);
    bus.clr_ovf = 1'b1;
    send_bit(1'b0, 1'b0);
    bus.clr_ovf = 1'b0;
    check("ovf_beats_clr", bus.ovf,      16'h1);
    check("ovf_beats_clr_data", bus.ch0_data, 16'h003C);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    pulse_ready(1'b0);
    check("ch0_empty_again", bus.ch0_valid, 16'h0);

    // Resync: 3 partial ones on ch1, sync with a bit present (dropped),
    // then a clean 0x81.
    send_bits(1'b1, 8'hFF, 3);
    bus.sync = 1'b1;
    send_bit(1'b1, 1'b1);
    bus.sync = 1'b0;
    check("sync_no_valid", bus.ch1_valid, 16'h0);
    send_bits(1'b1, 8'h81, W);
    check("sync_data",  bus.ch1_data,  16'h0081);
    check("sync_valid", bus.ch1_valid, 16'h1);

    // ch1 overflow maps onto ovf bit 1.
    send_bits(1'b1, 8'h7E, W);
    check("ovf_ch1",      bus.ovf,      16'h2);
    check("ovf_ch1_data", bus.ch1_data, 16'h0081);

    // Async reset mid-word on ch0 while ch1 holds an unaccepted word.
    send_bits(1'b0, 8'hFF, 5);
    rst_n = 1'b0;
    #1;
    check("arst_ch0_data",  bus.ch0_data,  16'h0000);
    check("arst_ch1_data",  bus.ch1_data,  16'h0000);
    check("arst_ch1_valid", bus.ch1_valid, 16'h0);
    check("arst_ovf",       bus.ovf,       16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send_bits(1'b0, 8'h12, W);
    check("post_rst_data",  bus.ch0_data,  16'h0012);
    check("post_rst_valid", bus.ch0_valid, 16'h1);
    check("post_rst_ch1_valid", bus.ch1_valid, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_deser2
